// File: rtl/lbus_pkg.sv
// Shared register map, control bit positions and parameter sanity check for the
// local-bus cipher interface.
package lbus_pkg;

    localparam logic [15:0] AddrCtrl     = 16'h0002;
    localparam logic [15:0] AddrMode     = 16'h000C;
    localparam logic [15:0] AddrLat      = 16'h000E;
    localparam logic [15:0] AddrKeyBase  = 16'h0100;
    localparam logic [15:0] AddrDinBase  = 16'h0140;
    localparam logic [15:0] AddrDoutBase = 16'h0180;
    localparam logic [15:0] AddrId       = 16'hFFFC;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlKey   = 1;
    localparam int unsigned CtrlCrst  = 2;
    localparam int unsigned CtrlClr   = 3;

    typedef struct packed {
        logic [10:0] rsvd;
        logic        err;
        logic        done;
        logic        rst_act;
        logic        kbusy;
        logic        dbusy;
    } ctrl_status_t;

    function automatic bit params_ok(input int unsigned key_w, input int unsigned din_w,
                                     input int unsigned dout_w, input int unsigned drdy_delay);
        return (key_w != 0) && (key_w % 16 == 0) &&
               (din_w != 0) && (din_w % 16 == 0) &&
               (dout_w != 0) && (dout_w % 16 == 0) &&
               (drdy_delay >= 1) && (drdy_delay <= 15);
    endfunction

endpackage

// File: rtl/lbus_wr_sync.sv
// Brings the asynchronous bus write strobe into the clk domain and emits a
// single-cycle trig_wr on each synchronised rising edge.
module lbus_wr_sync (
    input  logic clk,
    input  logic rst,
    input  logic lbus_wr,
    output logic trig_wr
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= lbus_wr;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign trig_wr = sync_q & ~prev_q;

endmodule

// File: rtl/lbus_cipher_if.sv
// Local-bus slave exposing key/data/mode/control registers of a block-cipher
// core, with handshake pulse generation, busy guards and latency measurement.
module lbus_cipher_if
    import lbus_pkg::*;
#(
    parameter int unsigned KEY_W      = 128,
    parameter int unsigned DIN_W      = 496,
    parameter int unsigned DOUT_W     = 128,
    parameter int unsigned DRDY_DELAY = 3,
    parameter logic [15:0] ID_VAL     = 16'h4702
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       lbus_a,
    input  logic [15:0]       lbus_di,
    input  logic              lbus_wr,
    input  logic              lbus_rd,
    output logic [15:0]       lbus_do,
    output logic [KEY_W-1:0]  blk_kin,
    output logic [DIN_W-1:0]  blk_din,
    input  logic [DOUT_W-1:0] blk_dout,
    output logic              blk_krdy,
    output logic              blk_drdy,
    input  logic              blk_kvld,
    input  logic              blk_dvld,
    output logic              blk_encdec,
    output logic              blk_en,
    output logic              blk_rstn
);

    localparam int unsigned KeyWords  = KEY_W / 16;
    localparam int unsigned DinWords  = DIN_W / 16;
    localparam int unsigned DoutWords = DOUT_W / 16;

    if (!params_ok(KEY_W, DIN_W, DOUT_W, DRDY_DELAY)) begin : g_param_check
        $fatal(1, "lbus_cipher_if: widths must be multiples of 16, DRDY_DELAY in 1..15");
    end

    logic trig_wr;

    lbus_wr_sync u_wr_sync (
        .clk     (clk),
        .rst     (rst),
        .lbus_wr (lbus_wr),
        .trig_wr (trig_wr)
    );

    logic [15:0]       do_q, do_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DIN_W-1:0]  din_q, din_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              encdec_q, encdec_d;
    logic              krdy_q, krdy_d, drdy_q, drdy_d, rstn_q, rstn_d;
    logic              dbusy_q, dbusy_d, kbusy_q, kbusy_d;
    logic              done_q, done_d, err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       lat_cnt_q, lat_cnt_d, lat_q, lat_d;

    logic wr_hit, wr_ctrl;
    logic start_req, key_req, crst_req, clr_req, start_ok, key_ok, err_set;
    ctrl_status_t status;
    logic [15:0] rd_mux;

    // Write decode: data registers commit directly on trig_wr.
    always_comb begin
        key_d    = key_q;
        din_d    = din_q;
        encdec_d = encdec_q;
        wr_hit   = 1'b0;
        wr_ctrl  = 1'b0;
        if (trig_wr) begin
            if (lbus_a == AddrCtrl) begin
                wr_ctrl = 1'b1;
                wr_hit  = 1'b1;
            end
            if (lbus_a == AddrMode) begin
                encdec_d = lbus_di[0];
                wr_hit   = 1'b1;
            end
            for (int i = 0; i < KeyWords; i++) begin
                if (lbus_a == AddrKeyBase + 16'(2 * i)) begin
                    key_d[KEY_W-1-16*i -: 16] = lbus_di;
                    wr_hit                    = 1'b1;
                end
            end
            for (int i = 0; i < DinWords; i++) begin
                if (lbus_a == AddrDinBase + 16'(2 * i)) begin
                    din_d[DIN_W-1-16*i -: 16] = lbus_di;
                    wr_hit                    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        start_req = wr_ctrl & lbus_di[CtrlStart];
        key_req   = wr_ctrl & lbus_di[CtrlKey];
        crst_req  = wr_ctrl & lbus_di[CtrlCrst];
        clr_req   = wr_ctrl & lbus_di[CtrlClr];
        start_ok  = start_req & ~dbusy_q;
        key_ok    = key_req & ~kbusy_q;
        err_set   = (start_req & dbusy_q) | (key_req & kbusy_q) | (trig_wr & ~wr_hit);

        krdy_d = key_ok;
        rstn_d = ~crst_req;

        // Set beats the W1C clear when both land in the same cycle.
        done_d = blk_dvld ? 1'b1 : (clr_req ? 1'b0 : done_q);
        err_d  = err_set ? 1'b1 : (clr_req ? 1'b0 : err_q);

        kbusy_d = kbusy_q;
        if (blk_kvld) kbusy_d = 1'b0;
        if (key_ok)   kbusy_d = 1'b1;

        dbusy_d = dbusy_q;
        if (blk_dvld) dbusy_d = 1'b0;
        if (start_ok) dbusy_d = 1'b1;

        cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        drdy_d = (cnt_q == 4'd1);
        if (start_ok) begin
            cnt_d  = 4'(DRDY_DELAY - 1);
            drdy_d = (DRDY_DELAY == 1);
        end

        // Core reset aborts any handshake in flight, including a due drdy.
        if (crst_req) begin
            kbusy_d = 1'b0;
            dbusy_d = 1'b0;
            cnt_d   = 4'd0;
            drdy_d  = 1'b0;
        end

        lat_cnt_d = lat_cnt_q;
        if (drdy_q) begin
            lat_cnt_d = 16'd0;
        end else if (dbusy_q && lat_cnt_q != 16'hFFFF) begin
            lat_cnt_d = lat_cnt_q + 16'd1;
        end
        lat_d  = blk_dvld ? lat_cnt_d : lat_q;
        dout_d = blk_dvld ? blk_dout : dout_q;
    end

    always_comb begin
        status         = '0;
        status.err     = err_q;
        status.done    = done_q;
        status.rst_act = ~rstn_q;
        status.kbusy   = kbusy_q;
        status.dbusy   = dbusy_q;

        rd_mux = 16'd0;
        if (lbus_a == AddrCtrl) rd_mux = status;
        if (lbus_a == AddrMode) rd_mux = {15'd0, encdec_q};
        if (lbus_a == AddrLat)  rd_mux = lat_q;
        if (lbus_a == AddrId)   rd_mux = ID_VAL;
        for (int i = 0; i < DoutWords; i++) begin
            if (lbus_a == AddrDoutBase + 16'(2 * i)) rd_mux = dout_q[DOUT_W-1-16*i -: 16];
        end
        do_d = lbus_rd ? do_q : rd_mux;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q      <= '0;
            key_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            encdec_q  <= 1'b0;
            krdy_q    <= 1'b0;
            drdy_q    <= 1'b0;
            rstn_q    <= 1'b1;
            dbusy_q   <= 1'b0;
            kbusy_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else begin
            do_q      <= do_d;
            key_q     <= key_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            encdec_q  <= encdec_d;
            krdy_q    <= krdy_d;
            drdy_q    <= drdy_d;
            rstn_q    <= rstn_d;
            dbusy_q   <= dbusy_d;
            kbusy_q   <= kbusy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            lat_cnt_q <= lat_cnt_d;
            lat_q     <= lat_d;
        end
    end

    assign lbus_do    = do_q;
    assign blk_kin    = key_q;
    assign blk_din    = din_q;
    assign blk_krdy   = krdy_q;
    assign blk_drdy   = drdy_q;
    assign blk_encdec = encdec_q;
    assign blk_en     = 1'b1;
    assign blk_rstn   = rstn_q;

endmodule

// File: tb/tb_lbus_cipher_if.sv
// Directed bench for lbus_cipher_if: bus writes/reads, handshake pulse timing,
// busy/err/done flags, core reset abort and asynchronous reset.
module tb_lbus_cipher_if;

    localparam logic [127:0] DoutVal = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
    localparam logic [127:0] KinVal  = 128'h0011_0022_0033_0044_0055_0066_0077_FFEE;

    logic         clk;
    logic         rst;
    logic [15:0]  lbus_a, lbus_di, lbus_do;
    logic         lbus_wr, lbus_rd;
    logic [127:0] blk_kin;
    logic [495:0] blk_din;
    logic [127:0] blk_dout = '0;
    logic         blk_krdy, blk_drdy, blk_encdec, blk_en, blk_rstn;
    logic         blk_kvld = 1'b0;
    logic         blk_dvld = 1'b0;

    lbus_cipher_if dut (
        .clk        (clk),
        .rst        (rst),
        .lbus_a     (lbus_a),
        .lbus_di    (lbus_di),
        .lbus_wr    (lbus_wr),
        .lbus_rd    (lbus_rd),
        .lbus_do    (lbus_do),
        .blk_kin    (blk_kin),
        .blk_din    (blk_din),
        .blk_dout   (blk_dout),
        .blk_krdy   (blk_krdy),
        .blk_drdy   (blk_drdy),
        .blk_kvld   (blk_kvld),
        .blk_dvld   (blk_dvld),
        .blk_encdec (blk_encdec),
        .blk_en     (blk_en),
        .blk_rstn   (blk_rstn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: dvld 20 cycles after drdy, kvld 30 cycles after krdy.
    int dv_cd = 0;
    int kv_cd = 0;
    always @(negedge clk) begin
        blk_dvld = 1'b0;
        blk_kvld = 1'b0;
        if (rst) begin
            dv_cd = 0;
            kv_cd = 0;
        end else begin
            if (blk_drdy) dv_cd = 20;
            else if (dv_cd > 0) begin
                dv_cd--;
                if (dv_cd == 0) blk_dvld = 1'b1;
            end
            if (blk_krdy) kv_cd = 30;
            else if (kv_cd > 0) begin
                kv_cd--;
                if (kv_cd == 0) blk_kvld = 1'b1;
            end
        end
        blk_dout = blk_dvld ? DoutVal : ~DoutVal;
    end

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse observation, indexed in negedges since the last watch_reset.
    int wt, drdy_cnt, drdy_at, krdy_cnt, krdy_at, rstn_cnt, rstn_at;

    task automatic watch_reset();
        wt = 0;
        drdy_cnt = 0; drdy_at = -1;
        krdy_cnt = 0; krdy_at = -1;
        rstn_cnt = 0; rstn_at = -1;
    endtask

    task automatic step();
        @(negedge clk);
        wt++;
        if (blk_drdy === 1'b1) begin
            drdy_cnt++;
            if (drdy_at < 0) drdy_at = wt;
        end
        if (blk_krdy === 1'b1) begin
            krdy_cnt++;
            if (krdy_at < 0) krdy_at = wt;
        end
        if (blk_rstn === 1'b0) begin
            rstn_cnt++;
            if (rstn_at < 0) rstn_at = wt;
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        watch_reset();
        lbus_a  = addr;
        lbus_di = data;
        lbus_wr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (wt == 4) lbus_wr = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        lbus_a  = addr;
        lbus_rd = 1'b0;
        step();
        data    = lbus_do;
        lbus_rd = 1'b1;
    endtask

    logic [15:0] rd;
    logic [15:0] kw [8];

    initial begin
        kw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'hFFEE};
        rst = 1'b1; lbus_a = '0; lbus_di = '0; lbus_wr = 1'b0; lbus_rd = 1'b1;
        watch_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        step();

        check("rst_do", 128'(lbus_do), 128'h0);
        check("rst_rstn", 128'(blk_rstn), 128'h1);
        check("rst_drdy", 128'(blk_drdy), 128'h0);
        check("rst_krdy", 128'(blk_krdy), 128'h0);
        check("rst_en", 128'(blk_en), 128'h1);
        bus_read(16'hFFFC, rd); check("id", 128'(rd), 128'h4702);
        bus_read(16'h0002, rd); check("rst_ctrl", 128'(rd), 128'h0);

        // Key load
        for (int i = 0; i < 8; i++) bus_write(16'h0100 + 16'(2 * i), kw[i]);
        check("kin", blk_kin, KinVal);
        bus_write(16'h0002, 16'h0002);
        check("krdy_at", 128'(krdy_at), 128'd3);
        check("krdy_cnt", 128'(krdy_cnt), 128'd1);
        check("krdy_nodrdy", 128'(drdy_cnt), 128'd0);
        bus_read(16'h0002, rd); check("kbusy", 128'(rd), 128'h0002);
        repeat (30) step();
        bus_read(16'h0002, rd); check("kbusy_clr", 128'(rd), 128'h0000);

        // Mode and data-in boundary words
        bus_write(16'h000C, 16'h0001);
        check("encdec", 128'(blk_encdec), 128'h1);
        bus_read(16'h000C, rd); check("mode_rd", 128'(rd), 128'h0001);
        bus_write(16'h0140, 16'hA5A5);
        bus_write(16'h017C, 16'h1234);
        check("din_w0", 128'(blk_din[495:480]), 128'hA5A5);
        check("din_w1", 128'(blk_din[479:464]), 128'h0);
        check("din_w30", 128'(blk_din[15:0]), 128'h1234);

        // Data operation
        bus_write(16'h0002, 16'h0001);
        check("drdy_at", 128'(drdy_at), 128'd5);
        check("drdy_cnt", 128'(drdy_cnt), 128'd1);
        bus_read(16'h0002, rd); check("dbusy", 128'(rd), 128'h0001);
        repeat (20) step();
        bus_read(16'h0180, rd); check("dout_w0", 128'(rd), 128'hDEAD);
        bus_read(16'h018E, rd); check("dout_w7", 128'(rd), 128'hBEEF);
        bus_read(16'h0002, rd); check("done", 128'(rd), 128'h0008);
        bus_read(16'h000E, rd); check("lat", 128'(rd), 128'd20);

        // Rejected second start, then W1C
        bus_write(16'h0002, 16'h0001);
        check("start2_drdy", 128'(drdy_cnt), 128'd1);
        bus_write(16'h0002, 16'h0001);
        check("rej_drdy", 128'(drdy_cnt), 128'd0);
        bus_read(16'h0002, rd); check("rej_err", 128'(rd), 128'h0019);
        repeat (10) step();
        bus_read(16'h0002, rd); check("rej_done", 128'(rd), 128'h0018);
        bus_read(16'h000E, rd); check("lat2", 128'(rd), 128'd20);
        bus_write(16'h0002, 16'h0008);
        bus_read(16'h0002, rd); check("w1c", 128'(rd), 128'h0000);

        // Start, then core reset two cycles later, before drdy is due
        watch_reset();
        lbus_a = 16'h0002; lbus_di = 16'h0001; lbus_wr = 1'b1;
        step(); lbus_wr = 1'b0;
        step(); lbus_wr = 1'b1;
        step(); lbus_di = 16'h0004;
        for (int k = 0; k < 30; k++) begin
            step();
            if (wt == 6) lbus_wr = 1'b0;
        end
        check("crst_rstn_at", 128'(rstn_at), 128'd5);
        check("crst_rstn_cnt", 128'(rstn_cnt), 128'd1);
        check("crst_nodrdy", 128'(drdy_cnt), 128'd0);
        bus_read(16'h0002, rd); check("crst_ctrl", 128'(rd), 128'h0000);
        check("crst_kin", blk_kin, KinVal);
        check("crst_din", 128'(blk_din[495:480]), 128'hA5A5);
        check("crst_mode", 128'(blk_encdec), 128'h1);

        // Unmapped and read-only writes
        bus_write(16'h0090, 16'h5A5A);
        bus_read(16'h0002, rd); check("unmap_err", 128'(rd), 128'h0010);
        bus_read(16'h0090, rd); check("unmap_rd", 128'(rd), 128'h0000);
        check("unmap_kin", blk_kin, KinVal);
        bus_write(16'h0002, 16'h0008);
        bus_write(16'h000E, 16'h5555);
        bus_read(16'h0002, rd); check("ro_err", 128'(rd), 128'h0010);
        bus_read(16'h000E, rd); check("ro_lat", 128'(rd), 128'd20);

        // Asynchronous reset mid-operation
        bus_write(16'h0002, 16'h0003);
        check("kd_drdy", 128'(drdy_cnt), 128'd1);
        check("kd_krdy", 128'(krdy_cnt), 128'd1);
        bus_read(16'hFFFC, rd);
        rst = 1'b1;
        #1;
        check("arst_do", 128'(lbus_do), 128'h0);
        check("arst_kin", blk_kin, 128'h0);
        check("arst_din", 128'(blk_din[495:480]), 128'h0);
        check("arst_mode", 128'(blk_encdec), 128'h0);
        check("arst_rstn", 128'(blk_rstn), 128'h1);
        repeat (2) step();
        rst = 1'b0;
        watch_reset();
        repeat (30) step();
        check("post_pulses", 128'(drdy_cnt + krdy_cnt + rstn_cnt), 128'd0);
        bus_read(16'h0002, rd); check("post_ctrl", 128'(rd), 128'h0000);
        bus_read(16'h000E, rd); check("post_lat", 128'(rd), 128'h0000);
        bus_read(16'h0180, rd); check("post_dout", 128'(rd), 128'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
